seq_alu_core: RTL and testbench

//  Parametrised, clocked successor to the combinational calculator datapath: one 4-bit opcode selects add/sub/mul/div/mod/logic/shift on WIDTH-bit unsigned operands.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_divider.sv | 63 ++++++
 rtl/seq_alu_core.sv | 187 ++++++++++++++++++
 tb/tb_seq_alu_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU core.
// Contents: opcode encodings, error codes and the FSM state type.
// The optional accumulator is enabled by the SEQ_ALU_ACC_EN macro in seq_alu_core.
package seq_alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_ACC = 4'd12;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StDivRun,
    StDone
  } state_e;

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle, WIDTH cycles per divide.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               load dividend/divisor and begin (divisor must be non-zero)
//   dividend, divisor   WIDTH-bit unsigned operands
//   busy                iteration in progress
//   done                high during the final iteration cycle; results are valid after that edge
//   quotient, remainder results, held until the next start
module seq_alu_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_shift, trial;

  // Partial remainder can reach 2*divisor-1, so the trial needs one extra bit.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH);
    end else if (busy) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign busy      = (cnt_q != '0);
  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_alu_core.sv
// Clocked ALU core: add/sub/logic/shift in one cycle, shift-add multiply and restoring
// divide/modulo in WIDTH iterations. Valid/ready handshake on input and output.
// Optional feature macro: SEQ_ALU_ACC_EN (accumulator, opcode 12 = ACC + in2).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake; in_ready only while idle
//   op, in1, in2          opcode and WIDTH-bit operands, captured on accept
//   out_valid / out_ready result handshake; result held until accepted
//   out                   2*WIDTH-bit result (upper half only used by MUL)
//   car                   carry (ADD/ACC) or borrow (SUB)
//   err                   00 none, 01 overflow, 10 divide by zero, 11 illegal opcode
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               car,
  output logic [1:0]         err
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam logic [CW-1:0] MulLast = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] res_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               car_q, use_div_q, sel_mod_q;
  logic [1:0]         err_q;

  logic               accept, div_start, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem, add_a, sc_res;
  logic [WIDTH:0]     sum, dif;
  logic               add_ovf, sub_ovf, sc_car;
  logic [1:0]         sc_err;

  assign accept    = in_valid && in_ready;
  assign div_start = accept && ((op == OP_DIV) || (op == OP_MOD)) && (in2 != '0);

`ifdef SEQ_ALU_ACC_EN
  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (out_valid && out_ready && (err_q == ERR_NONE)) begin
      acc_q <= out[WIDTH-1:0];
    end
  end

  assign add_a = (op == OP_ACC) ? acc_q : in1;
`else
  assign add_a = in1;
`endif

  assign sum     = {1'b0, add_a} + {1'b0, in2};
  assign dif     = {1'b0, in1} - {1'b0, in2};
  assign add_ovf = (add_a[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
  assign sub_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);

  // Single-cycle result, evaluated from the live inputs and registered on accept.
  always_comb begin
    sc_res = '0;
    sc_car = 1'b0;
    sc_err = ERR_NONE;
    case (op)
      OP_NOP: sc_res = '0;
      OP_ADD: begin
        {sc_car, sc_res} = sum;
        if (add_ovf) sc_err = ERR_OVF;
      end
      OP_SUB: begin
        {sc_car, sc_res} = dif;
        if (sub_ovf) sc_err = ERR_OVF;
      end
      OP_MUL: sc_res = '0;
      OP_DIV, OP_MOD: begin
        if (in2 == '0) sc_err = ERR_DIV0;
      end
      OP_AND: sc_res = in1 & in2;
      OP_OR:  sc_res = in1 | in2;
      OP_XOR: sc_res = in1 ^ in2;
      OP_NOT: sc_res = ~in1;
      OP_SHL: sc_res = in1 << in2[SHW-1:0];
      OP_SHR: sc_res = in1 >> in2[SHW-1:0];
`ifdef SEQ_ALU_ACC_EN
      OP_ACC: begin
        // in2 == 0 clears: the zero result is what the handshake loads back into acc_q.
        if (in2 != '0) begin
          {sc_car, sc_res} = sum;
          if (add_ovf) sc_err = ERR_OVF;
        end
      end
`endif
      default: sc_err = ERR_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OP_MUL)   state_d = StMulRun;
          else if (div_start) state_d = StDivRun;
          else                state_d = StDone;
        end
      end
      StMulRun: if (cnt_q == MulLast) state_d = StDone;
      // An idle divider here would otherwise hang the core.
      StDivRun: if (div_done || !div_busy) state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out       = use_div_q ? {{WIDTH{1'b0}}, (sel_mod_q ? div_rem : div_quo)} : res_q;
    car       = car_q;
    err       = err_q;
  end

  // Datapath: capture on accept, then shift-add while multiplying (res_q is the product).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      car_q     <= 1'b0;
      err_q     <= ERR_NONE;
      use_div_q <= 1'b0;
      sel_mod_q <= 1'b0;
    end else if (accept) begin
      res_q     <= {{WIDTH{1'b0}}, sc_res};
      mcand_q   <= {{WIDTH{1'b0}}, in1};
      mplier_q  <= in2;
      cnt_q     <= '0;
      car_q     <= sc_car;
      err_q     <= sc_err;
      use_div_q <= div_start;
      sel_mod_q <= (op == OP_MOD);
    end else if (state_q == StMulRun) begin
      if (mplier_q[0]) res_q <= res_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  seq_alu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (in1),
    .divisor  (in2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

endmodule

// File: tb/tb_seq_alu_core.sv
module tb_seq_alu_core;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_OVF  = 2'b01;
  localparam logic [1:0] E_DIV0 = 2'b10;
  localparam logic [1:0] E_ILL  = 2'b11;

  typedef struct packed {
    logic [31:0] out;
    logic        car;
    logic [1:0]  err;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic        car;
  logic [1:0]  err;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  seq_alu_core #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .car      (car),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one transaction and record the expected result.
  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] eo, input logic ec, input logic [1:0] ee,
                       input int el);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    op = o;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    in1 = 16'($urandom);
    in2 = 16'($urandom);
    e.out = eo;
    e.car = ec;
    e.err = ee;
    e.lat = 8'(el);
    sb.push_back(e);
  endtask

  // Wait for the next result, compare against the scoreboard, optionally hold it.
  task automatic retire(input string tag, input int hold);
    exp_t e;
    int lat = 0;
    e = sb.pop_front();
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 64);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
    chk({tag, "_out"}, 64'(dout), 64'(e.out));
    chk({tag, "_car"}, 64'(car), 64'(e.car));
    chk({tag, "_err"}, 64'(err), 64'(e.err));
    if (hold > 0) begin
      // New requests during backpressure must be ignored.
      in_valid = 1'b1;
      op = 4'd1;
      in1 = 16'h0009;
      in2 = 16'h0009;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_hold_out"}, 64'(dout), 64'(e.out));
        chk({tag, "_hold_err"}, 64'(err), 64'(e.err));
        chk({tag, "_hold_inrdy"}, 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rel_inrdy"}, 64'(in_ready), 64'(1));
    chk({tag, "_rel_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    int seen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_inrdy", 64'(in_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_out", 64'(dout), 64'(0));
    chk("rst_car", 64'(car), 64'(0));
    chk("rst_err", 64'(err), 64'(E_NONE));

    issue(4'd1, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, E_NONE, 1); retire("add_carry", 0);
    issue(4'd1, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b0, E_OVF, 1);  retire("add_ovf", 0);
    issue(4'd2, 16'h0003, 16'h0005, 32'h0000_FFFE, 1'b1, E_NONE, 1); retire("sub_borrow", 0);
    issue(4'd2, 16'h8000, 16'h0001, 32'h0000_7FFF, 1'b0, E_OVF, 1);  retire("sub_ovf", 0);

    issue(4'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, E_NONE, 17); retire("mul_max", 0);
    issue(4'd3, 16'd123, 16'd45, 32'(123 * 45), 1'b0, E_NONE, 17);   retire("mul_small", 0);

    issue(4'd4, 16'd100, 16'd7, 32'd14, 1'b0, E_NONE, 17);           retire("div", 0);
    issue(4'd5, 16'd100, 16'd7, 32'd2, 1'b0, E_NONE, 17);            retire("mod", 0);
    issue(4'd4, 16'hFFFF, 16'h0010, 32'h0FFF, 1'b0, E_NONE, 17);     retire("div_big", 0);
    issue(4'd5, 16'hFFFF, 16'h0010, 32'h000F, 1'b0, E_NONE, 17);     retire("mod_big", 0);
    issue(4'd4, 16'd5, 16'd0, 32'd0, 1'b0, E_DIV0, 1);               retire("div0", 0);
    issue(4'd5, 16'd5, 16'd0, 32'd0, 1'b0, E_DIV0, 1);               retire("mod0", 0);

    issue(4'd0, 16'h1234, 16'h5678, 32'h0, 1'b0, E_NONE, 1);         retire("nop", 0);
    issue(4'd6, 16'hF0F0, 16'hFF00, 32'hF000, 1'b0, E_NONE, 1);      retire("and", 0);
    issue(4'd7, 16'hF0F0, 16'hFF00, 32'hFFF0, 1'b0, E_NONE, 1);      retire("or", 0);
    issue(4'd8, 16'hF0F0, 16'hFF00, 32'h0FF0, 1'b0, E_NONE, 1);      retire("xor", 0);
    issue(4'd9, 16'h1234, 16'h0000, 32'hEDCB, 1'b0, E_NONE, 1);      retire("not", 0);
    issue(4'd10, 16'h8001, 16'h0001, 32'h0002, 1'b0, E_NONE, 1);     retire("shl", 0);
    issue(4'd11, 16'h8001, 16'h0013, 32'h1000, 1'b0, E_NONE, 1);     retire("shr", 0);

    issue(4'd14, 16'h1234, 16'h5678, 32'h0, 1'b0, E_ILL, 1);         retire("ill14", 0);
    issue(4'd15, 16'h1234, 16'h5678, 32'h0, 1'b0, E_ILL, 1);         retire("ill15", 0);

`ifdef SEQ_ALU_ACC_EN
    issue(4'd12, 16'h1111, 16'h0000, 32'h0, 1'b0, E_NONE, 1);        retire("acc_clr", 0);
    issue(4'd12, 16'h1111, 16'h0005, 32'd5, 1'b0, E_NONE, 1);        retire("acc_5", 0);
    issue(4'd12, 16'h2222, 16'h0003, 32'd8, 1'b0, E_NONE, 1);        retire("acc_8", 0);
`else
    issue(4'd12, 16'h0001, 16'h0005, 32'h0, 1'b0, E_ILL, 1);         retire("acc_ill", 0);
`endif

    // Backpressure: result held for 10 cycles, inputs offered meanwhile are dropped.
    issue(4'd1, 16'd2, 16'd3, 32'd5, 1'b0, E_NONE, 1);
    retire("bp", 10);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp_nodup", 64'(seen), 64'(0));

    // Reset in the middle of a multiply: no result may come out.
    issue(4'd3, 16'h1234, 16'h5678, 32'h0, 1'b0, E_NONE, 17);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_inrdy", 64'(in_ready), 64'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_noresult", 64'(seen), 64'(0));
    chk("mrst_out", 64'(dout), 64'(0));
    chk("mrst_inrdy_rel", 64'(in_ready), 64'(1));
    issue(4'd1, 16'd2, 16'd3, 32'd5, 1'b0, E_NONE, 1);               retire("post_rst_add", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
